// File: rtl/seq_signed_divider.sv
// -----------------------------------------------------------------------------
// seq_signed_divider
//
// Multi-cycle signed integer divider: quotient and remainder of two's-
// complement operands, computed with a radix-2 restoring algorithm on the
// operand magnitudes, one quotient bit per clock. Sits next to the
// combinational multi_op toolbox and talks valid/ready on both sides.
//
// Arithmetic: the quotient truncates toward zero and the remainder takes
// the sign of the dividend, so A = Q*B + R with |R| < |B|. Two operand
// pairs skip the iteration and finish in one cycle:
//   B == 0               -> Q = -1 (all ones), R = A[M-1:0], div_zero = 1
//   A == MIN, B == -1    -> Q = A, R = 0, ovf = 1
//
// Latency, counted from the cycle in which in_valid & in_ready is seen:
//   normal operands N+2 cycles, special operands 1 cycle.
//
// Parameters
//   N  dividend / quotient width (signed)
//   M  divisor / remainder width (signed), M <= N
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   abort      (only with DIV_ABORT_EN) drop the operation in flight
//   in_valid   operands valid
//   in_ready   divider idle and able to take operands
//   a          signed dividend, N bits
//   b          signed divisor, M bits
//   out_valid  result valid, held until out_ready
//   out_ready  consumer takes the result
//   q          signed quotient, N bits
//   r          signed remainder, M bits
//   div_zero   result came from a zero divisor
//   ovf        result came from MIN / -1
//
// Build option
//   DIV_ABORT_EN  adds the abort input. abort high while iterating or
//                 fixing signs returns to IDLE on the next edge; that
//                 operation never raises out_valid and q/r/flags keep
//                 their previous values. abort is ignored in IDLE/DONE.
// -----------------------------------------------------------------------------
module seq_signed_divider #(
  parameter int N = 64,
  parameter int M = 64
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef DIV_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic [M-1:0] r,
  output logic         div_zero,
  output logic         ovf
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  generate
    if (M > N) begin : g_bad_width
      $error("seq_signed_divider: M must not exceed N");
    end
    if (N < 2 || M < 1) begin : g_bad_size
      $error("seq_signed_divider: N must be >= 2 and M >= 1");
    end
  endgenerate

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Operand and working registers
  // ---------------------------------------------------------------------------
  logic          sign_a_q;   // dividend sign, selects remainder negation
  logic          sign_b_q;   // divisor sign, with sign_a_q selects quotient negation
  logic [N-1:0]  dvd_q;      // |A|, consumed MSB first by shifting left
  logic [M-1:0]  dsr_q;      // |B|
  logic [M-1:0]  rem_q;      // partial remainder, always < |B| between steps
  logic [N-1:0]  quot_q;     // quotient magnitude, bits shifted in from the LSB
  logic [CW-1:0] cnt_q;      // iteration index 0..N-1

  // ---------------------------------------------------------------------------
  // Operand decode (IDLE)
  // ---------------------------------------------------------------------------
  logic         a_neg;
  logic         b_neg;
  logic [N-1:0] a_mag;
  logic [M-1:0] b_mag;
  logic         b_is_zero;
  logic         a_is_min;
  logic         b_is_m1;
  logic         is_special;

  assign a_neg      = a[N-1];
  assign b_neg      = b[M-1];
  // The most-negative value maps onto itself, which read unsigned is
  // exactly its magnitude, so no extra bit is needed.
  assign a_mag      = a_neg ? -a : a;
  assign b_mag      = b_neg ? -b : b;
  assign b_is_zero  = (b == '0);
  assign a_is_min   = (a == {1'b1, {(N-1){1'b0}}});
  assign b_is_m1    = &b;
  assign is_special = b_is_zero | (a_is_min & b_is_m1);

  // ---------------------------------------------------------------------------
  // One restoring step (ITER)
  // ---------------------------------------------------------------------------
  logic [M:0]   rem_shift;   // remainder with the next dividend bit appended
  logic         fits;        // trial subtraction is non-negative
  logic [M-1:0] rem_diff;
  logic         last_iter;

  assign rem_shift = {rem_q, dvd_q[N-1]};
  assign fits      = (rem_shift >= {1'b0, dsr_q});
  // When the divisor fits, the true difference is below |B| <= 2^(M-1),
  // so the low M bits of the modular subtraction are exact.
  assign rem_diff  = rem_shift[M-1:0] - dsr_q;
  assign last_iter = (cnt_q == CW'(N - 1));

  // ---------------------------------------------------------------------------
  // Sign fix-up (FIX)
  // ---------------------------------------------------------------------------
  logic [N-1:0] quot_fixed;
  logic [M-1:0] rem_fixed;

  assign quot_fixed = (sign_a_q ^ sign_b_q) ? -quot_q : quot_q;
  assign rem_fixed  = sign_a_q ? -rem_q : rem_q;

  // ---------------------------------------------------------------------------
  // Abort request, only honoured while an operation is in flight
  // ---------------------------------------------------------------------------
  logic abort_hit;

`ifdef DIV_ABORT_EN
  assign abort_hit = abort && ((state_q == ITER) || (state_q == FIX));
`else
  assign abort_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  logic accept;

  // NOTE: every output of this block gets a default before the case, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = is_special ? DONE : ITER;
        end
      end
      ITER: begin
        if (abort_hit) begin
          state_d = IDLE;
        end else if (last_iter) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = abort_hit ? IDLE : DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  // The result registers are written only by the special-case load and by
  // FIX; everywhere else they hold the last delivered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      cnt_q    <= '0;
      q        <= '0;
      r        <= '0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            sign_a_q <= a_neg;
            sign_b_q <= b_neg;
            dvd_q    <= a_mag;
            dsr_q    <= b_mag;
            rem_q    <= '0;
            quot_q   <= '0;
            cnt_q    <= '0;
            if (b_is_zero) begin
              q        <= '1;
              r        <= a[M-1:0];
              div_zero <= 1'b1;
              ovf      <= 1'b0;
            end else if (a_is_min && b_is_m1) begin
              q        <= a;
              r        <= '0;
              div_zero <= 1'b0;
              ovf      <= 1'b1;
            end
          end
        end
        ITER: begin
          rem_q  <= fits ? rem_diff : rem_shift[M-1:0];
          quot_q <= {quot_q[N-2:0], fits};
          dvd_q  <= {dvd_q[N-2:0], 1'b0};
          cnt_q  <= cnt_q + CW'(1);
        end
        FIX: begin
          if (!abort_hit) begin
            q        <= quot_fixed;
            r        <= rem_fixed;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_signed_divider
//
// Self-checking bench for seq_signed_divider. A 64/64 instance is watched
// every cycle by a transaction-level model (busy flag, expected result from
// plain signed / and %, expected latency, last delivered result). An 8/8
// instance covers the narrow-width boundary cases. Directed operations pin
// hand-computed values; a randomized run follows.
// -----------------------------------------------------------------------------
module tb_seq_signed_divider;

  localparam int N = 64;
  localparam int M = 64;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] q;
  logic [63:0] r;
  logic        div_zero;
  logic        ovf;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b1;
  logic [7:0]  q8;
  logic [7:0]  r8;
  logic        div_zero8;
  logic        ovf8;

`ifdef DIV_ABORT_EN
  logic        abort = 1'b0;
  logic        abort8 = 1'b0;
`endif

  always #5 clk = ~clk;

  seq_signed_divider #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef DIV_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  seq_signed_divider #(.N(8), .M(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef DIV_ABORT_EN
    .abort     (abort8),
`endif
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .q         (q8),
    .r         (r8),
    .div_zero  (div_zero8),
    .ovf       (ovf8)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int     n_total = 0;
  int     n_pass  = 0;
  longint cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Transaction model of the 64-bit instance, compared every cycle
  // ---------------------------------------------------------------------------
  bit          m_busy = 1'b0;
  longint      m_acc  = 0;
  int          m_lat  = 0;
  logic [63:0] m_q, m_r, h_q, h_r;
  logic        m_dz, m_ovf, h_dz, h_ovf;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      h_q = '0; h_r = '0; h_dz = 1'b0; h_ovf = 1'b0;
      check("reset handshake", {62'd0, in_ready, out_valid}, 64'd2);
      check("reset q", q, 64'd0);
      check("reset r", r, 64'd0);
      check("reset flags", {62'd0, div_zero, ovf}, 64'd0);
    end else if (m_busy) begin
      bit done_now;
      done_now = (cyc - m_acc) >= longint'(m_lat);
      check("handshake busy", {62'd0, in_ready, out_valid}, {62'd0, 1'b0, done_now});
      check("q", q, done_now ? m_q : h_q);
      check("r", r, done_now ? m_r : h_r);
      check("flags", {62'd0, div_zero, ovf},
            done_now ? {62'd0, m_dz, m_ovf} : {62'd0, h_dz, h_ovf});
      if (done_now && out_ready) begin
        m_busy = 1'b0;
        h_q = m_q; h_r = m_r; h_dz = m_dz; h_ovf = m_ovf;
      end
`ifdef DIV_ABORT_EN
      if (!done_now && abort) m_busy = 1'b0;
`endif
    end else begin
      check("handshake idle", {62'd0, in_ready, out_valid}, 64'd2);
      check("q held", q, h_q);
      check("r held", r, h_r);
      check("flags held", {62'd0, div_zero, ovf}, {62'd0, h_dz, h_ovf});
      if (in_valid) begin
        m_busy = 1'b1;
        m_acc  = cyc;
        m_dz   = 1'b0;
        m_ovf  = 1'b0;
        if (b == 64'd0) begin
          m_q = '1; m_r = a; m_dz = 1'b1; m_lat = 1;
        end else if (a == MIN64 && b == '1) begin
          m_q = a; m_r = '0; m_ovf = 1'b1; m_lat = 1;
        end else begin
          m_q = $signed(a) / $signed(b);
          m_r = $signed(a) % $signed(b);
          m_lat = N + 2;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  // One operation on the 64-bit instance. hold > 0 keeps out_ready low for
  // that many cycles of DONE; poke drives a competing operand pair meanwhile.
  task automatic do_op(input logic [63:0] av, input logic [63:0] bv,
                       input int hold, input bit poke,
                       output logic [63:0] qv, output logic [63:0] rv,
                       output logic dz, output logic ov, output int lat);
    longint t0;
    bit     got;
    @(posedge clk); #1;
    a = av; b = bv; in_valid = 1'b1; out_ready = (hold == 0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
    end
    check("accept timeout", {63'd0, got}, 64'd1);
    t0 = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        lat = int'(cyc - t0);
      end
    end
    check("result timeout", {63'd0, got}, 64'd1);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      in_valid = poke; a = 64'd200; b = 64'd9;
    end
    qv = q; rv = r; dz = div_zero; ov = ovf;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv,
                        output logic [7:0] qv, output logic [7:0] rv,
                        output logic dz, output logic ov, output int lat);
    longint t0;
    bit     got;
    @(posedge clk); #1;
    a8 = av; b8 = bv; in_valid8 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = in_ready8;
    end
    check("dut8 accept timeout", {63'd0, got}, 64'd1);
    t0 = cyc;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (out_valid8) begin
        got = 1'b1;
        lat = int'(cyc - t0);
      end
    end
    check("dut8 result timeout", {63'd0, got}, 64'd1);
    qv = q8; rv = r8; dz = div_zero8; ov = ovf8;
    @(posedge clk); #1;
  endtask

`ifdef DIV_ABORT_EN
  // Start an operation, abort it k cycles after acceptance (1 <= k <= N),
  // then make sure no result ever shows up.
  task automatic abort_op(input logic [63:0] av, input logic [63:0] bv, input int k);
    bit got;
    @(posedge clk); #1;
    a = av; b = bv; in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
    end
    check("abort accept timeout", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (k) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    got = 1'b0;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    check("aborted op raised out_valid", {63'd0, got}, 64'd0);
    check("in_ready after abort", {63'd0, in_ready}, 64'd1);
  endtask
`endif

  function automatic logic [63:0] rand_val();
    logic [63:0] v;
    v = {$urandom(), $urandom()} >> $urandom_range(63, 0);
    if ($urandom_range(1, 0) == 1) v = -v;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [63:0] qv, rv, av, bv;
    logic [7:0]  q8v, r8v, eq8, er8;
    logic        dz, ov, edz, eov;
    int          lat, hold;

    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready/out_valid", {62'd0, in_ready, out_valid}, 64'd2);
    check("reset q literal", q, 64'd0);
    rst_n = 1'b1;

    // Sign combinations of 100 / 7
    do_op(64'd100, 64'd7, 0, 0, qv, rv, dz, ov, lat);
    check("100/7 q", qv, 64'd14);
    check("100/7 r", rv, 64'd2);
    check("100/7 flags", {62'd0, dz, ov}, 64'd0);
    check("100/7 latency", lat, 64'd66);
    do_op(-64'sd100, 64'd7, 0, 0, qv, rv, dz, ov, lat);
    check("-100/7 q", qv, -64'sd14);
    check("-100/7 r", rv, -64'sd2);
    do_op(64'd100, -64'sd7, 0, 0, qv, rv, dz, ov, lat);
    check("100/-7 q", qv, -64'sd14);
    check("100/-7 r", rv, 64'd2);
    do_op(-64'sd100, -64'sd7, 0, 0, qv, rv, dz, ov, lat);
    check("-100/-7 q", qv, 64'd14);
    check("-100/-7 r", rv, -64'sd2);

    // Divide by zero
    do_op(64'd55, 64'd0, 0, 0, qv, rv, dz, ov, lat);
    check("55/0 q", qv, 64'hFFFF_FFFF_FFFF_FFFF);
    check("55/0 r", rv, 64'd55);
    check("55/0 flags", {62'd0, dz, ov}, 64'd2);
    check("55/0 latency", lat, 64'd1);

    // Overflow at full width
    do_op(MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, qv, rv, dz, ov, lat);
    check("MIN/-1 q", qv, MIN64);
    check("MIN/-1 flags", {62'd0, dz, ov}, 64'd1);

    // Narrow instance boundaries
    do_op8(8'h80, 8'hFF, q8v, r8v, dz, ov, lat);
    check("8b -128/-1 q", {56'd0, q8v}, 64'h80);
    check("8b -128/-1 r", {56'd0, r8v}, 64'd0);
    check("8b -128/-1 flags", {62'd0, dz, ov}, 64'd1);
    check("8b -128/-1 latency", lat, 64'd1);
    do_op8(8'h80, 8'h01, q8v, r8v, dz, ov, lat);
    check("8b -128/1 q", {56'd0, q8v}, 64'h80);
    check("8b -128/1 r", {56'd0, r8v}, 64'd0);
    check("8b -128/1 flags", {62'd0, dz, ov}, 64'd0);
    check("8b -128/1 latency", lat, 64'd10);
    for (int i = 0; i < 40; i++) begin
      av = 64'($urandom());
      bv = 64'($urandom_range(7, 0) == 0 ? 0 : $urandom());
      edz = 1'b0; eov = 1'b0;
      if (bv[7:0] == 8'd0) begin
        eq8 = 8'hFF; er8 = av[7:0]; edz = 1'b1;
      end else if (av[7:0] == 8'h80 && bv[7:0] == 8'hFF) begin
        eq8 = 8'h80; er8 = 8'd0; eov = 1'b1;
      end else begin
        eq8 = $signed(av[7:0]) / $signed(bv[7:0]);
        er8 = $signed(av[7:0]) % $signed(bv[7:0]);
      end
      do_op8(av[7:0], bv[7:0], q8v, r8v, dz, ov, lat);
      check("8b random q", {56'd0, q8v}, {56'd0, eq8});
      check("8b random r", {56'd0, r8v}, {56'd0, er8});
      check("8b random flags", {62'd0, dz, ov}, {62'd0, edz, eov});
    end

    // Backpressure: DONE held 5 cycles with a competing request
    do_op(64'd100, 64'd7, 5, 1, qv, rv, dz, ov, lat);
    check("held q after backpressure", qv, 64'd14);
    check("held r after backpressure", rv, 64'd2);
    do_op(64'd200, 64'd9, 0, 0, qv, rv, dz, ov, lat);
    check("200/9 q", qv, 64'd22);
    check("200/9 r", rv, 64'd2);

    // Reset in the middle of an iteration
    @(posedge clk); #1;
    a = 64'd100; b = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset handshake", {62'd0, in_ready, out_valid}, 64'd2);
    check("async reset q", q, 64'd0);
    check("async reset r", r, 64'd0);
    check("async reset flags", {62'd0, div_zero, ovf}, 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized run, checked cycle by cycle by the model
    for (int i = 0; i < 1000; i++) begin
      av = rand_val();
      bv = rand_val();
      case ($urandom_range(39, 0))
        0: bv = 64'd0;
        1: bv = '1;
        2: av = MIN64;
        3: begin av = MIN64; bv = '1; end
        default: ;
      endcase
      hold = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
`ifdef DIV_ABORT_EN
      if ($urandom_range(19, 0) == 0) abort_op(av, bv, int'($urandom_range(N, 1)));
      else do_op(av, bv, hold, 1'b1, qv, rv, dz, ov, lat);
`else
      do_op(av, bv, hold, 1'b1, qv, rv, dz, ov, lat);
`endif
    end

`ifdef DIV_ABORT_EN
    abort_op(64'd1000, 64'd3, 10);
    abort_op(64'd1000, 64'd3, N);
    do_op(64'd1000, 64'd3, 0, 0, qv, rv, dz, ov, lat);
    check("after abort q", qv, 64'd333);
    check("after abort r", rv, 64'd1);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
